// File: rtl/counter_pkg.sv
// Shared constants for the multi-channel counter bank.
//   DEFAULT_WIDTH / DEFAULT_CHANNELS / DEFAULT_PRESCALE_DIV : parameter defaults
//   DIR_UP / DIR_DOWN   : encoding of the per-channel up_dn input
//   MODE_WRAP / MODE_SAT : encoding of the per-channel sat_mode input
package counter_pkg;

  localparam int DEFAULT_WIDTH        = 16;
  localparam int DEFAULT_CHANNELS     = 4;
  localparam int DEFAULT_PRESCALE_DIV = 4;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/counter_channel.sv
// One WIDTH-bit loadable up/down counter with terminal-count pulse,
// compare match and a sticky compare interrupt flag.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   step_tick      : shared step qualifier from the bank (1 = step allowed)
//   enable, load   : count enable, synchronous load strobe (load wins)
//   load_data      : value taken on load
//   up_dn          : direction (DIR_UP / DIR_DOWN)
//   sat_mode       : end behaviour (MODE_SAT / MODE_WRAP)
//   cmp_val        : compare value
//   irq_clr        : sticky flag clear pulse
//   count          : counter register
//   tc_pulse       : registered terminal-count pulse, aligned with new count
//   match          : combinational count == cmp_val
//   irq_flag       : sticky flag, set on the rising edge of match
module counter_channel
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             step_tick,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic             irq_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc_pulse,
  output logic             match,
  output logic             irq_flag
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic [WIDTH-1:0] count_next;
  logic             tc_next;
  logic             match_d;
  logic             match_rise;

  always_comb begin
    count_next = count;
    tc_next    = 1'b0;
    if (load) begin
      count_next = load_data;
    end else if (enable && step_tick) begin
      case (up_dn)
        DIR_UP: begin
          if (count == MAX_VAL) begin
            tc_next    = 1'b1;
            count_next = (sat_mode == MODE_WRAP) ? '0 : MAX_VAL;
          end else begin
            count_next = count + 1'b1;
          end
        end
        DIR_DOWN: begin
          if (count == '0) begin
            tc_next    = 1'b1;
            count_next = (sat_mode == MODE_SAT) ? '0 : MAX_VAL;
          end else begin
            count_next = count - 1'b1;
          end
        end
      endcase
    end
  end

  assign match      = (count == cmp_val);
  assign match_rise = match & ~match_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      tc_pulse <= 1'b0;
      match_d  <= 1'b0;
      irq_flag <= 1'b0;
    end else begin
      count    <= count_next;
      tc_pulse <= tc_next;
      match_d  <= match;
      // A fresh rising edge beats a clear issued in the same cycle; a match
      // that stays high does not re-arm the flag after a clear.
      if (match_rise) begin
        irq_flag <= 1'b1;
      end else if (irq_clr) begin
        irq_flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_channel_counter.sv
// Bank of CHANNELS independent WIDTH-bit up/down counters with per-channel
// compare flags and one combined interrupt.
// Build option: define COUNTER_PRESCALE_EN to add a shared prescaler so that
// steps happen once every PRESCALE_DIV cycles; undefined, every cycle steps.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   enable, load, up_dn, sat_mode, irq_clr : per-channel controls (1 bit each)
//   load_data, cmp_val : per-channel values, channel i at [i*WIDTH +: WIDTH]
//   count        : per-channel counter registers, same packing
//   tc_pulse, match, irq_flag : per-channel status
//   irq          : OR of all irq_flag bits
module multi_channel_counter
  import counter_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int CHANNELS     = DEFAULT_CHANNELS,
  parameter int PRESCALE_DIV = DEFAULT_PRESCALE_DIV
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] load_data,
  input  logic [CHANNELS-1:0]       up_dn,
  input  logic [CHANNELS-1:0]       sat_mode,
  input  logic [CHANNELS*WIDTH-1:0] cmp_val,
  input  logic [CHANNELS-1:0]       irq_clr,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       tc_pulse,
  output logic [CHANNELS-1:0]       match,
  output logic [CHANNELS-1:0]       irq_flag,
  output logic                      irq
);

  logic step_tick;

`ifdef COUNTER_PRESCALE_EN
  localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE_DIV - 1);

  logic [PW-1:0] prescaler;

  // Free-running and shared by all channels; loads do not disturb it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
    end else if (prescaler == PRE_LAST) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  assign step_tick = (prescaler == PRE_LAST);
`else
  // Every cycle is a step cycle; PRESCALE_DIV has no effect in this build.
  assign step_tick = 1'b1 | (PRESCALE_DIV == 0);
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    counter_channel #(
      .WIDTH (WIDTH)
    ) u_channel (
      .clk       (clk),
      .reset_n   (reset_n),
      .step_tick (step_tick),
      .enable    (enable[i]),
      .load      (load[i]),
      .load_data (load_data[i*WIDTH +: WIDTH]),
      .up_dn     (up_dn[i]),
      .sat_mode  (sat_mode[i]),
      .cmp_val   (cmp_val[i*WIDTH +: WIDTH]),
      .irq_clr   (irq_clr[i]),
      .count     (count[i*WIDTH +: WIDTH]),
      .tc_pulse  (tc_pulse[i]),
      .match     (match[i]),
      .irq_flag  (irq_flag[i])
    );
  end

  assign irq = |irq_flag;

endmodule
